mem_stage: RTL

- Memory-access pipeline stage. It sits between EX and the writeback stage.
- Registers the EX-to-MEM bus and waits for the variable-latency data-SRAM read response on loads.
- Performs byte/halfword extraction with sign/zero extension.
- Drives the MEM-to-WB bus and the HI/LO pass-through bus.
- Raises a stall request while a load response is outstanding, and provides MEM-stage forwarding outputs.

---
 rtl/mem_stage_pkg.sv | 48 ++++
 rtl/mem_stage_load_align.sv | 35 +++
 rtl/mem_stage.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared widths, bus layouts, load codes and FSM states for the MEM pipeline stage.
package mem_stage_pkg;

    localparam int unsigned EX_TO_MEM_WD  = 79;
    localparam int unsigned MEM_TO_WB_WD  = 70;
    localparam int unsigned HILO_WD       = 66;
    localparam int unsigned STALL_BUS_W   = 6;
    localparam int unsigned STALL_MEM_BIT = 3;
    localparam int unsigned STALL_WB_BIT  = 4;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic [2:0] LOAD_LB  = 3'b000;
    localparam logic [2:0] LOAD_LBU = 3'b001;
    localparam logic [2:0] LOAD_LH  = 3'b010;
    localparam logic [2:0] LOAD_LHU = 3'b011;
    localparam logic [2:0] LOAD_LW  = 3'b100;

    typedef struct packed {
        logic [31:0] pc;
        logic        data_ram_en;
        logic [3:0]  data_ram_wen;
        logic [2:0]  load_type;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
    } ex_to_mem_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
    } mem_to_wb_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    function automatic logic is_load(input ex_to_mem_t b);
        return b.data_ram_en && (b.data_ram_wen == 4'b0000);
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational byte/halfword selection with sign or zero extension for load data.
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  load_type,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        case (offset)
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            2'd3:    byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        half_sel = offset[1] ? word[31:16] : word[15:0];

        data = 32'h0;
        case (load_type)
            LOAD_LB:  data = {{24{byte_sel[7]}}, byte_sel};
            LOAD_LBU: data = {24'h0, byte_sel};
            LOAD_LH:  data = {{16{half_sel[15]}}, half_sel};
            LOAD_LHU: data = {16'h0, half_sel};
            LOAD_LW:  data = word;
            default:  data = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: registers EX results, waits for SRAM load responses, drives WB and forwarding.
// Optional load-wait cycle counter enabled by defining MEM_STAGE_PERF_CNT_EN.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [STALL_BUS_W-1:0]   stall,
    input  logic [EX_TO_MEM_WD-1:0]  ex_to_mem_bus,
    input  logic [HILO_WD-1:0]       hilo_ex_to_mem_bus,
    input  logic                     data_sram_rvalid,
    input  logic [31:0]              data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0]  mem_to_wb_bus,
    output logic [HILO_WD-1:0]       hilo_mem_to_wb_bus,
    output logic                     mem_wreg,
    output logic [4:0]               mem_waddr,
    output logic [31:0]              mem_wdata,
    output logic                     stallreq_for_mem
`ifdef MEM_STAGE_PERF_CNT_EN
    ,
    output logic [31:0]              load_wait_cycles
`endif
);

    ex_to_mem_t         ex_q, ex_d, in_bus;
    logic [HILO_WD-1:0] hilo_q, hilo_d;
    mem_state_e         state_q, state_d;
    logic [31:0]        rdata_buf_q, rdata_buf_d;
    logic               stall_mem, stall_wb, capture, capture_load;
    logic [31:0]        load_word, aligned, rf_wdata;
    logic               rf_we_eff;
    mem_to_wb_t         wb;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q        <= '0;
            hilo_q      <= '0;
            state_q     <= ST_IDLE;
            rdata_buf_q <= 32'h0;
        end else begin
            ex_q        <= ex_d;
            hilo_q      <= hilo_d;
            state_q     <= state_d;
            rdata_buf_q <= rdata_buf_d;
        end
    end

    // Pipeline register: capture, bubble or hold.
    always_comb begin
        stall_mem    = (stall[STALL_MEM_BIT] == STOP);
        stall_wb     = (stall[STALL_WB_BIT] == STOP);
        in_bus       = ex_to_mem_t'(ex_to_mem_bus);
        capture      = !stall_mem;
        capture_load = capture && is_load(in_bus);
        ex_d         = ex_q;
        hilo_d       = hilo_q;
        if (capture) begin
            ex_d   = in_bus;
            hilo_d = hilo_ex_to_mem_bus;
        end else if (!stall_wb) begin
            ex_d   = '0;
            hilo_d = '0;
        end
    end

    // Load-response FSM; a response that lands while WB is stalled is parked in rdata_buf.
    always_comb begin
        state_d          = state_q;
        rdata_buf_d      = rdata_buf_q;
        stallreq_for_mem = 1'b0;
        load_word        = 32'h0;
        case (state_q)
            ST_IDLE: begin
                if (capture_load) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                stallreq_for_mem = !data_sram_rvalid;
                load_word        = data_sram_rdata;
                if (data_sram_rvalid) begin
                    if (!stall_wb) begin
                        state_d = capture_load ? ST_WAIT : ST_IDLE;
                    end else begin
                        rdata_buf_d = data_sram_rdata;
                        state_d     = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                load_word = rdata_buf_q;
                if (!stall_wb) state_d = capture_load ? ST_WAIT : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    mem_stage_load_align u_load_align (
        .load_type (ex_q.load_type),
        .offset    (ex_q.ex_result[1:0]),
        .word      (load_word),
        .data      (aligned)
    );

    // Suppress write-back while the load data has not arrived yet.
    always_comb begin
        rf_wdata  = ex_q.sel_rf_res ? aligned : ex_q.ex_result;
        rf_we_eff = ex_q.rf_we;
        if (state_q == ST_WAIT && !data_sram_rvalid) begin
            rf_wdata  = 32'h0;
            rf_we_eff = 1'b0;
        end
        wb.pc              = ex_q.pc;
        wb.rf_we           = rf_we_eff;
        wb.rf_waddr        = ex_q.rf_waddr;
        wb.rf_wdata        = rf_wdata;
        mem_to_wb_bus      = wb;
        hilo_mem_to_wb_bus = hilo_q;
        mem_wreg           = rf_we_eff;
        mem_waddr          = ex_q.rf_waddr;
        mem_wdata          = rf_wdata;
    end

`ifdef MEM_STAGE_PERF_CNT_EN
    logic [31:0] wait_cnt_q, wait_cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) wait_cnt_q <= 32'h0;
        else      wait_cnt_q <= wait_cnt_d;
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (stallreq_for_mem) wait_cnt_d = wait_cnt_q + 32'd1;
    end

    assign load_wait_cycles = wait_cnt_q;
`endif

    logic unused_bits;
    assign unused_bits = ^{ex_q.data_ram_en, ex_q.data_ram_wen, stall[2:0], stall[STALL_BUS_W-1]};

endmodule
